// File: rtl/ov_cam_pkg.sv
// Shared definitions for the OV camera FIFO read path: FSM encoding and
// the read-pointer reset length.
package ov_cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RRST,
        ST_FETCH_HI,
        ST_FETCH_LO,
        ST_PUSH,
        ST_DONE
    } ov_state_e;

    localparam int RRST_CYCLES = 4;
    localparam int RRST_W      = $clog2(RRST_CYCLES);

endpackage

// File: rtl/ov_byte_packer.sv
// Packs captured camera bytes into OUT_W-bit words; a 16-bit word is
// published only once its second byte has arrived.
module ov_byte_packer #(
    parameter int OUT_W          = 16,
    parameter bit BYTE_MSB_FIRST = 1'b1
) (
    input  logic             CLK_40M,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             cap,
    input  logic [7:0]       byte_in,
    output logic [OUT_W-1:0] word
);

    generate
        if (OUT_W == 8) begin : g_w8
            always_ff @(posedge CLK_40M or negedge RST_N) begin
                if (!RST_N)   word <= '0;
                else if (cap) word <= byte_in;
            end
        end else if (OUT_W == 16) begin : g_w16
            logic [7:0] first;
            logic       phase;

            // clr discards a half-built word so an aborted frame leaves nothing behind
            always_ff @(posedge CLK_40M or negedge RST_N) begin
                if (!RST_N) begin
                    first <= '0;
                    phase <= 1'b0;
                    word  <= '0;
                end else if (clr) begin
                    phase <= 1'b0;
                end else if (cap) begin
                    if (!phase) begin
                        first <= byte_in;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        word  <= BYTE_MSB_FIRST ? {first, byte_in} : {byte_in, first};
                    end
                end
            end
        end else begin : g_bad_w
            $error("ov_byte_packer: OUT_W must be 8 or 16");
        end
    endgenerate

endmodule

// File: rtl/ov_fifo_reader.sv
// Reads one frame out of the camera FIFO (3 cycles per byte) and pushes
// packed words into the downstream FIFO, stalling on TX_WRFULL.
module ov_fifo_reader
    import ov_cam_pkg::*;
#(
    parameter int H_PIX          = 320,
    parameter int V_LINES        = 240,
    parameter int BPP            = 2,
    parameter int OUT_W          = 16,
    parameter bit BYTE_MSB_FIRST = 1'b1
) (
    input  logic             CLK_40M,
    input  logic             RST_N,
    input  logic             READ_EN,
    input  logic             ABORT,
    input  logic [7:0]       OV_DATA,
    input  logic             TX_WRFULL,
    output logic             OV_RRST,
    output logic             OV_RCLK,
    output logic [OUT_W-1:0] TX_DATA,
    output logic             TX_WRREQ,
    output logic             FRAME_BUSY,
    output logic             FRAME_DONE,
    output logic [15:0]      LINE_CNT
);

    localparam logic [31:0] LINE_BYTES  = 32'(H_PIX * BPP);
    localparam logic [31:0] FRAME_BYTES = 32'(H_PIX * V_LINES * BPP);
    localparam logic [15:0] LAST_LINE   = 16'(V_LINES - 1);

    generate
        if (BPP < 1 || BPP > 4) begin : g_bad_bpp
            $error("ov_fifo_reader: BPP must be 1..4");
        end
        if (OUT_W == 16 && FRAME_BYTES[0]) begin : g_bad_total
            $error("ov_fifo_reader: odd frame byte count with OUT_W=16");
        end
    endgenerate

    ov_state_e         state;
    logic [31:0]       byte_cnt;
    logic [31:0]       line_byte_cnt;
    logic [RRST_W-1:0] rrst_cnt;
    logic [OUT_W-1:0]  word;
    logic              cap;
    logic              clr;
    logic              push_due;

    assign cap      = (state == ST_FETCH_LO) && !ABORT;
    assign clr      = (state == ST_IDLE) || ABORT;
    assign push_due = (OUT_W == 8) || !byte_cnt[0];

    ov_byte_packer #(
        .OUT_W          (OUT_W),
        .BYTE_MSB_FIRST (BYTE_MSB_FIRST)
    ) u_packer (
        .CLK_40M (CLK_40M),
        .RST_N   (RST_N),
        .clr     (clr),
        .cap     (cap),
        .byte_in (OV_DATA),
        .word    (word)
    );

    // Outputs are registered with the state they belong to, so every
    // assignment below describes the state being entered.
    always_ff @(posedge CLK_40M or negedge RST_N) begin
        if (!RST_N) begin
            state         <= ST_IDLE;
            OV_RRST       <= 1'b1;
            OV_RCLK       <= 1'b1;
            TX_DATA       <= '0;
            TX_WRREQ      <= 1'b0;
            FRAME_BUSY    <= 1'b0;
            FRAME_DONE    <= 1'b0;
            LINE_CNT      <= '0;
            byte_cnt      <= '0;
            line_byte_cnt <= '0;
            rrst_cnt      <= '0;
        end else begin
            TX_WRREQ   <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (state != ST_IDLE && ABORT) begin
                state      <= ST_IDLE;
                OV_RRST    <= 1'b1;
                OV_RCLK    <= 1'b1;
                FRAME_BUSY <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        OV_RRST <= 1'b1;
                        OV_RCLK <= 1'b1;
                        if (READ_EN) begin
                            byte_cnt      <= '0;
                            line_byte_cnt <= '0;
                            LINE_CNT      <= '0;
                            rrst_cnt      <= '0;
                            OV_RRST       <= 1'b0;
                            OV_RCLK       <= 1'b0;
                            FRAME_BUSY    <= 1'b1;
                            state         <= ST_RRST;
                        end
                    end
                    ST_RRST: begin
                        if (rrst_cnt == RRST_W'(RRST_CYCLES - 1)) begin
                            OV_RRST <= 1'b1;
                            OV_RCLK <= 1'b1;
                            state   <= ST_FETCH_HI;
                        end else begin
                            rrst_cnt <= rrst_cnt + 1'b1;
                            OV_RCLK  <= ~OV_RCLK;
                        end
                    end
                    ST_FETCH_HI: begin
                        OV_RCLK <= 1'b0;
                        state   <= ST_FETCH_LO;
                    end
                    ST_FETCH_LO: begin
                        // rising OV_RCLK here advances the camera FIFO to the next byte
                        OV_RCLK  <= 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (line_byte_cnt == LINE_BYTES - 1) begin
                            line_byte_cnt <= '0;
                            if (LINE_CNT < LAST_LINE) LINE_CNT <= LINE_CNT + 1'b1;
                        end else begin
                            line_byte_cnt <= line_byte_cnt + 1'b1;
                        end
                        state <= ST_PUSH;
                    end
                    ST_PUSH: begin
                        if (!push_due) begin
                            state <= ST_FETCH_HI;
                        end else if (!TX_WRFULL) begin
                            TX_WRREQ <= 1'b1;
                            TX_DATA  <= word;
                            if (byte_cnt == FRAME_BYTES) begin
                                FRAME_DONE <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                state <= ST_FETCH_HI;
                            end
                        end
                    end
                    ST_DONE: begin
                        FRAME_BUSY <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Directed bench: 4x2 frame, 2 bytes/pixel, read by a 16-bit and an 8-bit reader.
module tb_ov_fifo_reader;

    logic        CLK_40M = 1'b0;
    logic        RST_N = 1'b0, READ_EN = 1'b0, ABORT = 1'b0, TX_WRFULL = 1'b0;
    logic [7:0]  d16, d8, tx8;
    logic        rrst16, rclk16, wr16, busy16, done16;
    logic        rrst8, rclk8, wr8, busy8, done8;
    logic [15:0] tx16, lc16, lc8;

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0, tdone = 0, tl1 = 0, dn16 = 0, dn8 = 0;
    int p16 = 0, p8 = 0;
    logic        rrst_d = 1'b1;
    logic [15:0] lc_d = '0;
    logic [15:0] q16[$];
    logic [7:0]  q8[$];
    int          tq16[$], tq8[$];

    always #5 CLK_40M = ~CLK_40M;

    ov_fifo_reader #(.H_PIX(4), .V_LINES(2), .BPP(2), .OUT_W(16), .BYTE_MSB_FIRST(1'b1)) u_dut16 (
        .CLK_40M(CLK_40M), .RST_N(RST_N), .READ_EN(READ_EN), .ABORT(ABORT), .OV_DATA(d16),
        .TX_WRFULL(TX_WRFULL), .OV_RRST(rrst16), .OV_RCLK(rclk16), .TX_DATA(tx16),
        .TX_WRREQ(wr16), .FRAME_BUSY(busy16), .FRAME_DONE(done16), .LINE_CNT(lc16));

    ov_fifo_reader #(.H_PIX(4), .V_LINES(2), .BPP(2), .OUT_W(8), .BYTE_MSB_FIRST(1'b1)) u_dut8 (
        .CLK_40M(CLK_40M), .RST_N(RST_N), .READ_EN(READ_EN), .ABORT(ABORT), .OV_DATA(d8),
        .TX_WRFULL(TX_WRFULL), .OV_RRST(rrst8), .OV_RCLK(rclk8), .TX_DATA(tx8),
        .TX_WRREQ(wr8), .FRAME_BUSY(busy8), .FRAME_DONE(done8), .LINE_CNT(lc8));

    // Camera FIFO models: pointer cleared by RCLK edges under RRST, else advanced.
    always @(posedge rclk16) p16 <= rrst16 ? p16 + 1 : 0;
    always @(posedge rclk8)  p8  <= rrst8  ? p8 + 1  : 0;
    assign d16 = p16[7:0];
    assign d8  = p8[7:0];

    always @(negedge CLK_40M) begin
        cyc    <= cyc + 1;
        rrst_d <= rrst16;
        lc_d   <= lc16;
        if (!rrst_d && rrst16) t0 <= cyc;
        if (lc16 == 16'd1 && lc_d == 16'd0) tl1 <= cyc;
        if (wr16) begin q16.push_back(tx16); tq16.push_back(cyc); end
        if (wr8)  begin q8.push_back(tx8);   tq8.push_back(cyc);  end
        if (done16) begin dn16 <= dn16 + 1; tdone <= cyc; end
        if (done8)  dn8 <= dn8 + 1;
    end

    task automatic tick();
        @(negedge CLK_40M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q16.delete(); tq16.delete(); q8.delete(); tq8.delete();
    endtask

    task automatic wait_done(input string tag, input int start_dn);
        for (int i = 0; i < 400 && dn16 == start_dn; i++) tick();
        chk(tag, 32'(dn16 != start_dn), 32'd1);
    endtask

    task automatic check_data(input string tag);
        chk({tag, "_n16"}, q16.size(), 8);
        for (int j = 0; j < 8 && j < q16.size(); j++)
            chk({tag, "_d16"}, q16[j], 16'h0001 + 16'h0202 * 16'(j));
        chk({tag, "_n8"}, q8.size(), 16);
        for (int j = 0; j < 16 && j < q8.size(); j++)
            chk({tag, "_d8"}, q8[j], j);
    endtask

    initial begin
        logic r;
        int edges, wrs;

        // Reset values
        tick(); tick();
        chk("rst_rrst", rrst16, 1); chk("rst_rclk", rclk16, 1); chk("rst_wrreq", wr16, 0);
        chk("rst_data", tx16, 0);   chk("rst_busy", busy16, 0); chk("rst_done", done16, 0);
        chk("rst_line", lc16, 0);
        RST_N = 1'b1;
        tick(); tick();

        // Frame 1: RRST sequence, data, timing, line counter
        clear_q();
        READ_EN = 1'b1; tick(); READ_EN = 1'b0;
        chk("rrst_c0", {rrst16, rclk16}, 2'b00); chk("busy_on", busy16, 1);
        tick(); chk("rrst_c1", {rrst16, rclk16}, 2'b01);
        tick(); chk("rrst_c2", {rrst16, rclk16}, 2'b00);
        tick(); chk("rrst_c3", {rrst16, rclk16}, 2'b01);
        tick(); chk("rrst_end", {rrst16, rclk16}, 2'b11);
        chk("line0", lc16, 0);
        wait_done("f1_done", 0);
        chk("f1_done_t", tdone - t0, 48);
        chk("f1_last_push_t", (q16.size() == 8) ? tq16[7] - t0 : -1, 48);
        chk("f1_line1_t", tl1 - t0, 23);
        tick();
        chk("f1_busy_off", busy16, 0);
        repeat (4) tick();
        check_data("f1");
        chk("f1_line_sat", lc16, 1);
        chk("f1_done_cnt", dn16, 1);
        chk("f1_done8_cnt", dn8, 1);
        chk("f1_rate8", (q8.size() >= 2) ? tq8[1] - tq8[0] : -1, 3);
        chk("f1_first8_t", (q8.size() >= 1) ? tq8[0] - t0 : -1, 3);

        // Frame 2: downstream full for 10 cycles at the third push
        clear_q();
        READ_EN = 1'b1; tick(); READ_EN = 1'b0;
        for (int i = 0; i < 200 && q16.size() < 2; i++) tick();
        chk("f2_two_pushes_t", tq16.size() == 2 ? tq16[1] - t0 : -1, 12);
        repeat (5) tick();
        TX_WRFULL = 1'b1;
        r = rclk16; edges = 0; wrs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rclk16 !== r) edges++;
            if (wr16) wrs++;
            r = rclk16;
        end
        TX_WRFULL = 1'b0;
        chk("f2_stall_rclk", edges, 0);
        chk("f2_stall_wrreq", wrs, 0);
        wait_done("f2_done", 1);
        chk("f2_done_t", tdone - t0, 58);
        repeat (3) tick();
        check_data("f2");

        // Frame 3: abort after 5 bytes, coinciding with an 8-bit push decision
        clear_q();
        READ_EN = 1'b1; tick(); READ_EN = 1'b0;
        for (int i = 0; i < 200 && q16.size() < 2; i++) tick();
        tick(); tick();
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        chk("ab_busy", busy16, 0); chk("ab_rrst", rrst16, 1); chk("ab_rclk", rclk16, 1);
        chk("ab_wr16", wr16, 0);   chk("ab_wr8", wr8, 0);
        repeat (20) tick();
        chk("ab_n16", q16.size(), 2);
        chk("ab_n8", q8.size(), 4);
        chk("ab_no_done", dn16, 2);

        // Frame 4: clean restart, READ_EN held high through DONE
        clear_q();
        READ_EN = 1'b1; tick();
        chk("f4_rrst", rrst16, 0);
        wait_done("f4_done", 2);
        tick();
        chk("f4_idle_busy", busy16, 0); chk("f4_idle_rrst", rrst16, 1);
        tick();
        chk("f4_restart_rrst", rrst16, 0); chk("f4_restart_busy", busy16, 1);
        READ_EN = 1'b0;
        check_data("f4");

        // Reset pulse mid-frame
        repeat (20) tick();
        clear_q();
        RST_N = 1'b0; #1;
        chk("mr_rrst", rrst16, 1); chk("mr_rclk", rclk16, 1); chk("mr_wr", wr16, 0);
        chk("mr_data", tx16, 0);   chk("mr_busy", busy16, 0); chk("mr_done", done16, 0);
        chk("mr_line", lc16, 0);
        tick(); tick();
        RST_N = 1'b1;
        repeat (30) tick();
        chk("mr_no_push16", q16.size(), 0);
        chk("mr_no_push8", q8.size(), 0);
        chk("mr_idle", busy16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
